// File: rtl/avalon_st_mul_responder.sv
// avalon_st_mul_responder: receives an A/B operand packet on the sink stream,
// multiplies with a radix-4 shift-add engine and returns the full-width
// product as a byte-serial packet on the source stream.
//
// state | meaning
// RECV  | sink ready, collecting operand beats
// CALC  | one radix-4 partial product added per cycle
// SEND  | product streamed out LSB byte first
module avalon_st_mul_responder #(
  parameter int SZ  = 32,
  parameter int DSZ = 8
) (
  input  logic           clk,
  input  logic           _rst,
  input  logic           valid_in,
  input  logic [DSZ-1:0] data_in,
  input  logic           startofpacket_in,
  input  logic           endofpacket_in,
  output logic           ready_out,
  output logic           valid_out,
  output logic [DSZ-1:0] data_out,
  output logic           startofpacket_out,
  output logic           endofpacket_out,
  input  logic           ready_in
);

  localparam int N  = 2 * SZ / DSZ;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int IW = (SZ / 2 > 1) ? $clog2(SZ / 2) : 1;
  localparam int BW = 2 * SZ - DSZ;

  localparam logic [CW-1:0] BEAT_LAST = CW'(N - 1);
  localparam logic [IW-1:0] ITER_LAST = IW'(SZ / 2 - 1);

  localparam logic [1:0] S_RECV = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_SEND = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [BW-1:0]   buf_q, buf_d;
  logic [SZ-1:0]   a_q, a_d;
  logic [SZ-1:0]   mplier_q, mplier_d;
  logic [2*SZ-1:0] acc_q, acc_d;
  logic [IW-1:0]   iter_q, iter_d;
  logic [CW-1:0]   idx_q, idx_d;
  logic            ready_q, ready_d;
  logic            valid_q, valid_d;
  logic [DSZ-1:0]  data_q, data_d;
  logic            sop_q, sop_d;
  logic            eop_q, eop_d;
  logic [2*SZ-1:0] pp;

  // Next-state logic for framing, multiply iterations and output sequencing.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    buf_d    = buf_q;
    a_d      = a_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    iter_d   = iter_q;
    idx_d    = idx_q;
    ready_d  = ready_q;
    valid_d  = valid_q;
    data_d   = data_q;
    sop_d    = sop_q;
    eop_d    = eop_q;
    pp       = '0;

    case (state_q)
      S_RECV: begin
        ready_d = 1'b1;
        if (valid_in && ready_q) begin
          if (startofpacket_in) begin
            // SOP always restarts capture; SOP+EOP is a runt and is dropped.
            buf_d[DSZ-1:0] = data_in;
            cnt_d = endofpacket_in ? '0 : CW'(1);
          end else if (cnt_q != '0) begin
            if (endofpacket_in) begin
              cnt_d = '0;
              if (cnt_q == BEAT_LAST) begin
                // Last beat is the top byte of B; it goes straight into the multiplier.
                a_d      = buf_q[SZ-1:0];
                mplier_d = {data_in, buf_q[BW-1:SZ]};
                acc_d    = '0;
                iter_d   = '0;
                ready_d  = 1'b0;
                state_d  = S_CALC;
              end
            end else if (cnt_q == BEAT_LAST) begin
              // Packet longer than N beats: discard it.
              cnt_d = '0;
            end else begin
              for (int k = 1; k < N - 1; k++) begin
                if (cnt_q == CW'(k)) buf_d[k*DSZ +: DSZ] = data_in;
              end
              cnt_d = cnt_q + CW'(1);
            end
          end
        end
      end

      S_CALC: begin
        case (mplier_q[1:0])
          2'd1:    pp = {{SZ{1'b0}}, a_q};
          2'd2:    pp = {{(SZ-1){1'b0}}, a_q, 1'b0};
          2'd3:    pp = {{SZ{1'b0}}, a_q} + {{(SZ-1){1'b0}}, a_q, 1'b0};
          default: pp = '0;
        endcase
        acc_d    = acc_q + (pp << {iter_q, 1'b0});
        mplier_d = mplier_q >> 2;
        iter_d   = iter_q + IW'(1);
        if (iter_q == ITER_LAST) begin
          state_d = S_SEND;
          idx_d   = '0;
          valid_d = 1'b1;
          data_d  = acc_d[DSZ-1:0];
          sop_d   = 1'b1;
          eop_d   = 1'b0;
        end
      end

      S_SEND: begin
        if (ready_in) begin
          if (idx_q == BEAT_LAST) begin
            state_d = S_RECV;
            idx_d   = '0;
            valid_d = 1'b0;
            data_d  = '0;
            sop_d   = 1'b0;
            eop_d   = 1'b0;
            ready_d = 1'b1;
          end else begin
            idx_d = idx_q + CW'(1);
            sop_d = 1'b0;
            eop_d = (idx_d == BEAT_LAST);
            for (int k = 0; k < N; k++) begin
              if (idx_d == CW'(k)) data_d = acc_q[k*DSZ +: DSZ];
            end
          end
        end
      end

      default: state_d = S_RECV;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!_rst) begin
      state_q  <= S_RECV;
      cnt_q    <= '0;
      buf_q    <= '0;
      a_q      <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      iter_q   <= '0;
      idx_q    <= '0;
      ready_q  <= 1'b0;
      valid_q  <= 1'b0;
      data_q   <= '0;
      sop_q    <= 1'b0;
      eop_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      buf_q    <= buf_d;
      a_q      <= a_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      iter_q   <= iter_d;
      idx_q    <= idx_d;
      ready_q  <= ready_d;
      valid_q  <= valid_d;
      data_q   <= data_d;
      sop_q    <= sop_d;
      eop_q    <= eop_d;
    end
  end

  assign ready_out         = ready_q;
  assign valid_out         = valid_q;
  assign data_out          = data_q;
  assign startofpacket_out = sop_q;
  assign endofpacket_out   = eop_q;

endmodule

// File: tb/tb_avalon_st_mul_responder.sv
// Bench for avalon_st_mul_responder: vector table of products plus directed
// framing, backpressure, reset and random soak sequences.
module tb_avalon_st_mul_responder;

  localparam int N = 8;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] p;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       valid_in = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       sop_in = 1'b0;
  logic       eop_in = 1'b0;
  logic       ready_in = 1'b1;
  logic       ready_out, valid_out, sop_out, eop_out;
  logic [7:0] data_out;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int rdy_mode = 0;

  int          beat = 0;
  logic [63:0] res = '0;
  logic [63:0] out_q[$];
  int          out_count = 0;
  int          valid_cycles = 0;
  int          vrise_cyc = 0;
  bit          prev_valid = 0;
  bit          stall_pend = 0;
  bit          post_eop = 0;
  logic [7:0]  st_data = '0;
  logic        st_sop = 0;
  logic        st_eop = 0;

  vec_t vecs[8];

  avalon_st_mul_responder #(.SZ(32), .DSZ(8)) dut (
    .clk               (clk),
    ._rst              (rst_n),
    .valid_in          (valid_in),
    .data_in           (data_in),
    .startofpacket_in  (sop_in),
    .endofpacket_in    (eop_in),
    .ready_out         (ready_out),
    .valid_out         (valid_out),
    .data_out          (data_out),
    .startofpacket_out (sop_out),
    .endofpacket_out   (eop_out),
    .ready_in          (ready_in)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       ready_in = 1'b1;
      1:       ready_in = ~ready_in;
      default: ready_in = 1'($urandom_range(0, 1));
    endcase
  end

  task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Output monitor: assembles packets and checks framing/stall rules.
  always @(negedge clk) begin
    if (!rst_n) begin
      beat = 0;
      stall_pend = 0;
      post_eop = 0;
      prev_valid = 0;
    end else begin
      if (post_eop) begin
        check(!valid_out && ready_out, "idle_after_eop", {valid_out, ready_out}, 2'b01);
        post_eop = 0;
      end
      if (stall_pend)
        check(valid_out && data_out == st_data && sop_out == st_sop && eop_out == st_eop, "stall_hold",
              {valid_out, sop_out, eop_out, data_out}, {1'b1, st_sop, st_eop, st_data});
      if (beat != 0) check(valid_out, "valid_mid_pkt", valid_out, 1);
      if (!valid_out) check(!sop_out && !eop_out, "sop_eop_idle", {sop_out, eop_out}, 0);
      if (valid_out) begin
        valid_cycles++;
        if (!prev_valid) vrise_cyc = cyc;
        check(!ready_out, "ready_low_busy", ready_out, 0);
      end
      stall_pend = valid_out && !ready_in;
      st_data = data_out;
      st_sop = sop_out;
      st_eop = eop_out;
      if (valid_out && ready_in) begin
        check(sop_out == (beat == 0), "sop_pos", sop_out, (beat == 0));
        check(eop_out == (beat == N - 1), "eop_pos", eop_out, (beat == N - 1));
        res[beat*8 +: 8] = data_out;
        beat++;
        if (beat == N || eop_out) begin
          out_q.push_back(res);
          out_count++;
          post_eop = eop_out;
          beat = 0;
        end
      end
      prev_valid = valid_out;
    end
  end

  task automatic send_beat(input logic [7:0] d, input logic s, input logic e, input int gap, output int edge_cyc);
    int guard;
    repeat (gap) begin
      valid_in = 1'b0;
      @(posedge clk); #1;
    end
    valid_in = 1'b1;
    data_in = d;
    sop_in = s;
    eop_in = e;
    guard = 0;
    while (!ready_out && guard < 3000) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 3000) check(1'b0, "sink_ready_timeout", ready_out, 1);
    @(posedge clk); #1;
    edge_cyc = cyc;
    valid_in = 1'b0;
    sop_in = 1'b0;
    eop_in = 1'b0;
  endtask

  task automatic send_pkt(input logic [31:0] a, input logic [31:0] b, input int maxgap, output int e);
    logic [7:0] d;
    int gap;
    for (int i = 0; i < N; i++) begin
      d = (i < 4) ? a[i*8 +: 8] : b[(i-4)*8 +: 8];
      gap = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
      send_beat(d, (i == 0), (i == N - 1), gap, e);
    end
  endtask

  task automatic get_result(input logic [63:0] exp, input string name);
    int guard;
    logic [63:0] got;
    guard = 0;
    while (out_q.size() == 0 && guard < 3000) begin
      @(posedge clk); #1;
      guard++;
    end
    if (out_q.size() == 0) begin
      check(1'b0, {name, "_timeout"}, 0, exp);
    end else begin
      got = out_q.pop_front();
      check(got == exp, name, got, exp);
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int e, c0, v0;
    logic [31:0] ra, rb;

    vecs[0] = '{32'd10234,      32'd566,        64'h0000_0000_0058_62BC};
    vecs[1] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  64'hFFFF_FFFE_0000_0001};
    vecs[2] = '{32'd3,          32'd5,          64'd15};
    vecs[3] = '{32'h0,          32'h1234_5678,  64'h0};
    vecs[4] = '{32'h1,          32'hFFFF_FFFF,  64'h0000_0000_FFFF_FFFF};
    vecs[5] = '{32'h8000_0000,  32'h2,          64'h0000_0001_0000_0000};
    vecs[6] = '{32'h1234_5678,  32'h10,         64'h0000_0001_2345_6780};
    vecs[7] = '{32'h0001_0000,  32'h0001_0000,  64'h0000_0001_0000_0000};

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check(ready_out == 0, "rst_ready", ready_out, 0);
    check(valid_out == 0, "rst_valid", valid_out, 0);
    check(data_out == 0, "rst_data", data_out, 0);
    check(!sop_out && !eop_out, "rst_sop_eop", {sop_out, eop_out}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check(ready_out == 1, "ready_after_reset", ready_out, 1);

    for (int i = 0; i < 8; i++) begin
      send_pkt(vecs[i].a, vecs[i].b, 0, e);
      check(ready_out == 0, "ready_drop_after_eop", ready_out, 0);
      get_result(vecs[i].p, "vec_product");
      check(vrise_cyc == e + 16, "latency", vrise_cyc, e + 16);
    end

    // Backpressure with ready_in toggling every cycle.
    rdy_mode = 1;
    send_pkt(32'd537321351, 32'd24627837, 0, e);
    get_result(64'd13233062649047787, "bp_product");
    rdy_mode = 0;

    // EOP on beat 4: packet dropped, no output.
    c0 = out_count;
    for (int i = 0; i < 5; i++) send_beat(8'(8'h10 + i), (i == 0), (i == 4), 0, e);
    repeat (40) @(posedge clk);
    #1;
    check(out_count == c0, "short_pkt_no_output", out_count - c0, 0);
    check(ready_out == 1, "short_pkt_ready", ready_out, 1);
    send_pkt(32'd3, 32'd5, 0, e);
    get_result(64'h0F, "after_short_pkt");

    // SOP re-asserted on beat 5 restarts capture.
    c0 = out_count;
    for (int i = 0; i < 5; i++) send_beat(8'(8'hE0 + i), (i == 0), 1'b0, 0, e);
    send_pkt(32'h0102_0304, 32'h0000_0100, 0, e);
    get_result(64'h0000_0001_0203_0400, "sop_restart");
    check(out_count == c0 + 1, "sop_restart_count", out_count - c0, 1);

    // Stray non-SOP beats with the count at zero are discarded.
    send_beat(8'hAA, 1'b0, 1'b0, 0, e);
    send_beat(8'h55, 1'b0, 1'b1, 0, e);
    send_pkt(32'h2, 32'h8000_0000, 0, e);
    get_result(64'h0000_0001_0000_0000, "stray_beats");

    // Reset in the middle of CALC.
    c0 = out_count;
    v0 = valid_cycles;
    send_pkt(32'hDEAD_BEEF, 32'h1234_5678, 0, e);
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check(ready_out == 0, "ready_in_reset_1", ready_out, 0);
    check(valid_out == 0, "valid_in_reset", valid_out, 0);
    @(posedge clk); #1;
    check(ready_out == 0, "ready_in_reset_2", ready_out, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check(ready_out == 1, "ready_after_release", ready_out, 1);
    repeat (40) @(posedge clk);
    #1;
    check(valid_cycles == v0, "no_valid_after_reset", valid_cycles - v0, 0);
    check(out_count == c0, "no_pkt_after_reset", out_count - c0, 0);
    send_pkt(32'd7, 32'd9, 0, e);
    get_result(64'd63, "after_reset");

    // Random soak with input gaps and random ready_in.
    rdy_mode = 2;
    c0 = out_count;
    for (int i = 0; i < 200; i++) begin
      ra = $urandom;
      rb = $urandom;
      send_pkt(ra, rb, 2, e);
      get_result({32'h0, ra} * {32'h0, rb}, "soak_product");
    end
    check(out_count - c0 == 200, "soak_pkt_count", out_count - c0, 200);
    rdy_mode = 0;

    repeat (5) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/avalon_st_mul_responder.md
# avalon_st_mul_responder

Avalon-ST responder for the multiplier link: accepts an operand packet (A then B, byte-serial, SOP/EOP framed) from the master wrapper, computes the 2·SZ-bit product with an iterative radix-4 shift-add engine, and returns the product as a byte-serial packet on the reverse stream. It sits on the slave side of the link, clocked by the clock the master forwards (`out_clk` at system level).

## Interface
- `SZ`, 32: operand width in bits; must be an even multiple of DSZ.
- `DSZ`, 8: stream symbol width in bits.
- `clk`  in  1  rising-edge clock.
- `_rst`  in  1  reset, synchronous, active-low.
- `valid_in`  in  1  sink beat valid.
- `data_in`  in  DSZ  sink beat data.
- `startofpacket_in`  in  1  sink SOP.
- `endofpacket_in`  in  1  sink EOP.
- `ready_out`  out  1  sink ready; ready latency 0.
- `valid_out`  out  1  source beat valid.
- `data_out`  out  DSZ  source beat data.
- `startofpacket_out`  out  1  source SOP.
- `endofpacket_out`  out  1  source EOP.
- `ready_in`  in  1  source ready from master; ready latency 0.

## Operation
- Beat count N = 2·SZ/DSZ (8 by default) for both input and output packets.
- Input packet: beats 0..N/2-1 carry A LSB-byte first, beats N/2..N-1 carry B LSB-byte first; SOP on beat 0, EOP on beat N-1.
- Output packet: N beats carrying RES = A·B (unsigned, 2·SZ bits, no truncation), LSB byte first; SOP on beat 0, EOP on beat N-1.
- States: RECV, CALC, SEND.
- RECV: `ready_out`=1. A beat is accepted when `valid_in` and `ready_out` are both 1 at a rising edge; `valid_in` while `ready_out`=0 is ignored.
  - SOP beat: always stored as beat 0 and the count restarts, even mid-packet.
  - Non-SOP beat while the count is 0: discarded.
  - EOP on beat N-1 with SOP seen: load operands, clear the accumulator and the iteration counter, go to CALC.
  - EOP on any other beat: drop the packet, clear the count, stay in RECV.
  - SOP and EOP on the same beat: treated as a short packet and dropped.
- CALC: `ready_out`=0. Each cycle: acc += A·(multiplier[1:0]) << 2·i, then shift the multiplier right by 2. SZ/2 iterations (16 by default), then go to SEND with the beat index at 0.
- SEND: present byte[index] of RES. When `valid_out` and `ready_in` are both 1 at an edge, index increments. When the EOP beat is accepted, go to RECV.
- Reset (`_rst`=0 at an edge), in any state: go to RECV, clear all counters, drop any partial input or pending result.

## Timing
- All outputs are registered. Values while `_rst` is low: `ready_out`=0, `valid_out`=0, `data_out`=0, SOP/EOP out =0.
- `ready_out`=1 from the first cycle after the first edge with `_rst`=1.
- Latency:
  - Last input beat accepted at edge E.
  - `ready_out` is 0 from the cycle after E.
  - `valid_out` rises with beat 0 after edge E+SZ/2 (E+16).
- With `ready_in` held at 1, one output beat is sent per cycle. The full round trip is N + SZ/2 + N = 32 cycles minimum.
- Backpressure: while `valid_out`=1 and `ready_in`=0, `data_out`, SOP and EOP must hold stable. `valid_out` never drops mid-packet.
- After the EOP output beat is accepted at edge F: `valid_out`=0 and `ready_out`=1 in the cycle after F. There are no dead cycles beyond this one.
- SOP and EOP outputs are valid only while `valid_out`=1; both are 0 otherwise.

## Test plan
- Basic product: A=10234, B=566 sent as bytes FA 27 00 00 36 02 00 00, `ready_in` high -> output BC 62 58 00 00 00 00 00. SOP on the first output beat, EOP on the last. `valid_out` rises 16 cycles after the input EOP edge.
- Maximum operands: A=B=0xFFFFFFFF -> output 01 00 00 00 FE FF FF FF; the bench checks that no bits are lost.
- Backpressure: A=537321351, B=24627837, with `ready_in` toggled every cycle -> output outputs stable while stalled, 8 beats total, product matches the reference model, `ready_out` stays 0 until the EOP output beat is accepted.
- Framing errors:
  - EOP asserted on input beat 4 -> no output packet, `ready_out` stays 1.
  - A following valid packet A=3, B=5 -> output 0F 00 00 00 00 00 00 00.
  - SOP re-asserted on input beat 5 -> capture restarts, and that beat is byte 0 of A.
- Reset mid-operation: `_rst` driven low for 2 cycles during CALC -> `valid_out` never rises. `ready_out` is 0 during reset and 1 in the cycle after release. A following packet A=7, B=9 -> 63.
- Random soak: 200 packets with random A and B and random `valid_in`/`ready_in` gaps -> every result equals the 64-bit A·B, and one output packet is produced per well-formed input packet.
